// File: rtl/alu_wide_sequencer.sv
// Splits one WORDS*8-bit request into byte operations on the 8-bit registered ALU,
// chaining carry LSB-first, and returns the assembled result over a valid/ready channel.
module alu_wide_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [8*WORDS-1:0]   req_a,
  input  logic [8*WORDS-1:0]   req_b,
  input  logic                 req_carry_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*WORDS-1:0]   rsp_y,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_negative,
  output logic                 rsp_err,
  output logic                 alu_en,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic                 alu_carry_in,
  output logic                 alu_sat_enable,
  output logic [1:0]           alu_cmp_mode,
  output logic [2:0]           alu_shift_amt,
  input  logic [7:0]           alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero,
  input  logic                 alu_negative
);

  localparam int unsigned W  = 8 * WORDS;
  localparam int unsigned KW = $clog2(WORDS);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            chain_q, chain_d;
  logic [KW-1:0]   k_q, k_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_y_q, rsp_y_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_negative_q, rsp_negative_d;
  logic            rsp_err_q, rsp_err_d;

  logic            alu_en_q, alu_en_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic            alu_cin_q, alu_cin_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= 3'd0;
      a_q            <= '0;
      b_q            <= '0;
      cin_q          <= 1'b0;
      chain_q        <= 1'b0;
      k_q            <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_y_q        <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b1;
      rsp_negative_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      alu_en_q       <= 1'b0;
      alu_op_q       <= 3'd0;
      alu_a_q        <= 8'd0;
      alu_b_q        <= 8'd0;
      alu_cin_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      cin_q          <= cin_d;
      chain_q        <= chain_d;
      k_q            <= k_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_y_q        <= rsp_y_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      rsp_err_q      <= rsp_err_d;
      alu_en_q       <= alu_en_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_cin_q      <= alu_cin_d;
    end
  end

  // Next-state, result assembly and registered ALU drive
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    cin_d          = cin_q;
    chain_d        = chain_q;
    k_d            = k_q;
    rsp_y_d        = rsp_y_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    rsp_err_d      = rsp_err_q;
    alu_en_d       = 1'b0;
    alu_op_d       = 3'd0;
    alu_a_d        = 8'd0;
    alu_b_d        = 8'd0;
    alu_cin_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d           = req_op;
          a_d            = req_a;
          b_d            = req_b;
          cin_d          = req_carry_in;
          chain_d        = 1'b0;
          k_d            = '0;
          rsp_y_d        = '0;
          rsp_carry_d    = 1'b0;
          rsp_zero_d     = 1'b1;
          rsp_negative_d = 1'b0;
          rsp_err_d      = (req_op > OP_XOR);
          state_d        = (req_op > OP_XOR) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_y_d[8*k_q +: 8] = alu_y;
        rsp_zero_d          = rsp_zero_q & alu_zero;
        chain_d             = alu_carry_out;
        if (k_q == KW'(WORDS - 1)) begin
          rsp_negative_d = alu_negative;
          rsp_carry_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_carry_out : 1'b0;
          state_d        = S_RESP;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_ISSUE;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An error response spends one cycle in RESP before rsp_valid rises
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP) && (state_q != S_IDLE);

    if (state_d == S_ISSUE) begin
      alu_en_d = 1'b1;
      alu_a_d  = a_d[8*k_d +: 8];
      alu_b_d  = b_d[8*k_d +: 8];
      case (op_d)
        OP_ADD: begin
          alu_op_d  = OP_ADD;
          alu_cin_d = (k_d == '0) ? cin_d : chain_d;
        end
        OP_SUB: begin
          // Upper bytes add ~b with the not-borrow chain
          if (k_d == '0) begin
            alu_op_d  = OP_SUB;
            alu_cin_d = 1'b0;
          end else begin
            alu_op_d  = OP_ADD;
            alu_b_d   = ~b_d[8*k_d +: 8];
            alu_cin_d = chain_d;
          end
        end
        default: begin
          alu_op_d  = op_d;
          alu_cin_d = 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_y          = rsp_y_q;
  assign rsp_carry      = rsp_carry_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_negative   = rsp_negative_q;
  assign rsp_err        = rsp_err_q;
  assign alu_en         = alu_en_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_carry_in   = alu_cin_q;
  assign alu_sat_enable = 1'b0;
  assign alu_cmp_mode   = 2'd0;
  assign alu_shift_amt  = 3'd0;

endmodule
